// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode helpers for the registered
// multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_AND   = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0010;
  localparam logic [3:0] ALU_SLL   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_LUI   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_SRA   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_mul(input logic [3:0] aluc);
    return (aluc == ALU_MUL) || (aluc == ALU_MULHU);
  endfunction

endpackage

// File: rtl/alu_shift.sv
// Combinational barrel shifter: logical left, logical right or arithmetic right.
module alu_shift #(
  parameter  int W   = 32,
  localparam int SAW = $clog2(W)
) (
  input  logic [W-1:0]   d,
  input  logic [SAW-1:0] sa,
  input  logic           right,
  input  logic           arith,
  output logic [W-1:0]   sh
);

  always_comb begin
    if (!right)     sh = d << sa;
    else if (arith) sh = $signed(d) >>> sa;
    else            sh = d >> sa;
  end

endmodule

// File: rtl/alu_mc.sv
// Registered ALU with valid/ready handshakes; single-cycle ops plus an
// iterative unsigned shift-add multiplier (MUL low half, MULHU high half).
module alu_mc
  import alu_pkg::*;
#(
  parameter int W      = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   aluc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r,
  output logic         z,
  output logic         ovf,
  output logic         ill
);

  localparam int SAW = $clog2(W);

  state_t         state_q, state_d;
  logic [W-1:0]   r_q, r_d;
  logic           z_q, z_d, ovf_q, ovf_d, ill_q, ill_d, ov_q, ov_d;
  logic [W-1:0]   acc_q, acc_d, mplier_q, mplier_d, mcand_q, mcand_d;
  logic [SAW-1:0] cnt_q, cnt_d;
  logic           hi_q, hi_d;

  logic           accept, mul_op;
  logic [W-1:0]   sum, diff, sh, res_c;
  logic           ovf_c, ill_c;
  logic [W:0]     step;

  assign accept = in_valid && in_ready;
  assign mul_op = MUL_EN && is_mul(aluc);
  assign sum    = a + b;
  assign diff   = a - b;

  alu_shift #(.W(W)) u_shift (
    .d     (b),
    .sa    (a[SAW-1:0]),
    .right ((aluc == ALU_SRL) || (aluc == ALU_SRA)),
    .arith (aluc == ALU_SRA),
    .sh    (sh)
  );

  // Single-cycle result; MUL/MULHU fall into the illegal default when MUL_EN=0.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    res_c = '0;
    ovf_c = 1'b0;
    ill_c = 1'b0;
    case (aluc)
      ALU_ADD: begin
        res_c = sum;
        ovf_c = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        res_c = diff;
        ovf_c = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      ALU_AND:                   res_c = a & b;
      ALU_OR:                    res_c = a | b;
      ALU_XOR:                   res_c = a ^ b;
      ALU_LUI:                   res_c = b << (W / 2);
      ALU_SLL, ALU_SRL, ALU_SRA: res_c = sh;
      ALU_SLT:  res_c = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: res_c = {{(W-1){1'b0}}, a < b};
      default:  ill_c = 1'b1;
    endcase
  end

  // One shift-add step: the carry out of acc becomes the new acc MSB.
  assign step = {1'b0, acc_q} + {1'b0, mcand_q & {W{mplier_q[0]}}};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= S_IDLE;
    // NOTE: sequential state uses non-blocking assignments only.
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && mul_op) state_d = S_MULT;
      S_MULT:  if (cnt_q == SAW'(W - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE) && (!ov_q || out_ready);
  end

  always_comb begin
    ov_d     = ov_q && !out_ready;
    r_d      = r_q;
    z_d      = z_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    if (accept && !mul_op) begin
      ov_d  = 1'b1;
      r_d   = res_c;
      z_d   = (res_c == '0);
      ovf_d = ovf_c;
      ill_d = ill_c;
    end else if (accept) begin
      acc_d    = '0;
      mplier_d = b;
      mcand_d  = a;
      cnt_d    = '0;
      hi_d     = (aluc == ALU_MULHU);
    end else if (state_q == S_MULT) begin
      acc_d    = step[W:1];
      mplier_d = {step[0], mplier_q[W-1:1]};
      cnt_d    = cnt_q + SAW'(1);
    end else if (state_q == S_DONE) begin
      ov_d  = 1'b1;
      r_d   = hi_q ? acc_q : mplier_q;
      z_d   = (r_d == '0);
      ovf_d = 1'b0;
      ill_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ov_q     <= 1'b0;
      r_q      <= '0;
      z_q      <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
    end else begin
      ov_q     <= ov_d;
      r_q      <= r_d;
      z_q      <= z_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
    end
  end

  assign out_valid = ov_q;
  assign r         = r_q;
  assign z         = z_q;
  assign ovf       = ovf_q;
  assign ill       = ill_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered successor to the pipeline's combinational EX-stage ALU.
- Executes add/sub/logic/shift/LUI/set-less-than in one cycle and unsigned shift-add multiply iteratively.
- Valid/ready handshakes on both sides let the EX stage stall on multi-cycle ops.
- Adds overflow and illegal-op flags, which the combinational ALU does not have.

Parameters:
- W, 32: datapath width; power of two, >= 8.
- MUL_EN, 1: 1 enables MUL/MULHU; 0 makes them illegal and removes the multiplier.
- SAW, $clog2(W): localparam; shift-amount width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clrn  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- aluc  in  4  opcode.
- a  in  W  operand A; a[SAW-1:0] is the shift amount.
- b  in  W  operand B; shift/LUI source.
- out_valid  out  1  r/z/ovf/ill hold a result.
- out_ready  in  1  consumer takes the result.
- r  out  W  result.
- z  out  1  r == 0.
- ovf  out  1  signed overflow (ADD/SUB only, else 0).
- ill  out  1  undefined opcode; r = 0.

Behaviour:
- Reset (clrn=0, asynchronous, also mid-multiply):
  - state IDLE; r=0, z=0, ovf=0, ill=0, out_valid=0; multiplier registers cleared.
  - In-flight op is discarded. in_ready=1 from the first cycle after release.
- Opcode map (aluc):
  - 0000 ADD, 0100 SUB, 0001 AND, 0101 OR, 0010 XOR.
  - 0110 LUI: b << (W/2).
  - 0011 SLL: b << sa. 0111 SRL: b >> sa. 1111 SRA: arithmetic right shift of b by sa.
  - 1000 SLT: signed a<b → 1 else 0. 1001 SLTU: unsigned compare.
  - 1010 MUL: low W bits of a*b. 1011 MULHU: high W bits of unsigned a*b.
  - All other codes are illegal: r=0, ill=1, z=1, latency 1.
- Arithmetic: modulo 2^W. ovf = signed overflow of a+b or a-b.
- Handshake:
  - Accept when in_valid && in_ready at a rising edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready), so output consume and new accept can occur in the same cycle.
  - Output is held stable while out_valid && !out_ready.
  - out_valid clears on consume unless a new result is loaded on the same edge.
- FSM:
  - IDLE: on accept of a single-cycle op, load r/flags; out_valid=1 after that edge (latency 1). On accept of MUL/MULHU (MUL_EN=1), latch a, b, opcode; acc=0; cnt=0; go to MULT.
  - MULT: each cycle, if mplier[0] then acc += mcand; shift {acc,mplier} right by 1; cnt++. When cnt==W-1, go to DONE.
  - DONE: load r from the 2W product (low or high half), z from r, ovf=0, ill=0; set out_valid; go to IDLE.
- MUL latency: the accepting edge is E0; out_valid rises at edge E(W+1). in_ready=0 throughout MULT and DONE.
- Inputs are ignored while not ready; operands need not stay stable after acceptance.

Decomposition:
- Package alu_pkg holds:
  - localparams for all opcodes (ALU_ADD … ALU_MULHU);
  - FSM state encodings S_IDLE, S_MULT, S_DONE;
  - a function is_mul(aluc).
- Sub-module alu_shift (d, sa, right, arith → sh), combinational, W-parametrised.
- Single-cycle datapath and FSM stay in alu_mc.

Test Plan:
1. Reset mid-multiply: drive MUL, then pulse clrn low for 2 cycles at cycle 5 → out_valid=0 and r=0 immediately; in_ready=1 after release; no stale result appears.
2. W=32, ADD a=7FFFFFFF b=00000001 → after 1 cycle out_valid=1, r=80000000, ovf=1, z=0. SUB a=5 b=5 → r=0, z=1, ovf=0.
3. Shifts: SRA b=F0000000 a=4 → F F000000; SRL same operands → 0F000000; SLL b=1 a=31 → 80000000. LUI b=00001234 → 12340000. SLT a=FFFFFFFF b=1 → 1; SLTU same operands → 0.
4. MUL/MULHU a=FFFFFFFF b=FFFFFFFF:
   - MUL → r=00000001 after exactly 33 cycles; in_ready=0 during cycles 1-32.
   - MULHU → r=FFFFFFFE.
   - With MUL_EN=0 → ill=1, r=0, latency 1.
5. Back-pressure:
   - Hold out_ready=0 with ADD result pending → r stable and in_ready=0 for 10 cycles.
   - Raise out_ready with in_valid=1 (XOR a=F0 b=FF) → new r=0000000F on the next edge; out_valid stays 1.
6. Back-to-back throughput: 8 single-cycle ops with out_ready=1 → one result per cycle, in order. Illegal aluc=1100 → ill=1, r=0, z=1.
